// File: rtl/aes_pkg.sv
// Shared types, constants and helpers for the AES-128 key-expansion path.
package aes_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned KEY_W  = 128;

  localparam logic [BYTE_W-1:0] RCON_INIT  = 8'h01;
  localparam logic [BYTE_W-1:0] XTIME_POLY = 8'h1B;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StEmit,
    StSubReq,
    StSubWait,
    StMix
  } key_exp_state_t;

  // Multiply by x in GF(2^8).
  function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] b);
    return {b[BYTE_W-2:0], 1'b0} ^ (b[BYTE_W-1] ? XTIME_POLY : '0);
  endfunction

  function automatic logic [WORD_W-1:0] rot_word(input logic [WORD_W-1:0] w);
    return {w[WORD_W-BYTE_W-1:0], w[WORD_W-1 -: BYTE_W]};
  endfunction

endpackage

// File: rtl/sub_word_seq.sv
// SubWord byte loop: streams one byte at a time to the external S-box, collects the
// substituted bytes and watches for a stalled S-box.
module sub_word_seq
  import aes_pkg::*;
#(
  parameter int unsigned SBOX_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic              req_i,
  input  logic              wait_i,
  input  logic              sbox_done_i,
  input  logic [BYTE_W-1:0] sbox_data_out_i,
  output logic              sbox_enable_o,
  output logic [BYTE_W-1:0] sbox_data_in_o,
  output logic              byte_done_o,
  output logic              word_done_o,
  output logic              timeout_o,
  output logic [WORD_W-1:0] word_o
);

  localparam int unsigned WdW = $clog2(SBOX_TIMEOUT + 1);

  logic [WORD_W-1:0] temp_q, temp_d;
  logic [1:0]        j_q, j_d;
  logic [WdW-1:0]    wd_q, wd_d;
  logic [4:0]        sel;

  // Byte 0 lives in the most significant lane.
  assign sel = {~j_q, 3'b000};

  always_comb begin
    temp_d      = temp_q;
    j_d         = j_q;
    wd_d        = wd_q;
    byte_done_o = wait_i & sbox_done_i;
    word_done_o = byte_done_o & (j_q == 2'd3);
    timeout_o   = wait_i & ~sbox_done_i & (wd_q == WdW'(SBOX_TIMEOUT - 1));
    if (load_i) begin
      temp_d = rot_word(word_i);
      j_d    = '0;
    end
    if (req_i) begin
      wd_d = '0;
    end
    if (byte_done_o) begin
      temp_d[sel +: BYTE_W] = sbox_data_out_i;
      j_d                   = j_q + 2'd1;
    end else if (wait_i) begin
      wd_d = wd_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      temp_q <= '0;
      j_q    <= '0;
      wd_q   <= '0;
    end else begin
      temp_q <= temp_d;
      j_q    <= j_d;
      wd_q   <= wd_d;
    end
  end

  assign sbox_enable_o  = req_i;
  assign sbox_data_in_o = temp_q[sel +: BYTE_W];
  assign word_o         = temp_q;

endmodule

// File: rtl/key_exp_ctrl.sv
// AES-128 key-schedule sequencer: emits round keys 0..NUM_ROUNDS, one valid pulse each,
// using an external byte-serial S-box for SubWord.
module key_exp_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS   = 10,
  parameter int unsigned SBOX_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [KEY_W-1:0]  key_in,
  output logic              busy,
  output logic [KEY_W-1:0]  round_key,
  output logic              round_key_valid,
  output logic [3:0]        round_idx,
  output logic              done,
  output logic              error,
  output logic              sbox_enable,
  output logic [BYTE_W-1:0] sbox_data_in,
  input  logic [BYTE_W-1:0] sbox_data_out,
  input  logic              sbox_done
);

  key_exp_state_t state_q, state_d;

  logic [KEY_W-1:0]  words_q, words_d;
  logic [KEY_W-1:0]  rk_q, rk_d;
  logic [BYTE_W-1:0] rcon_q, rcon_d;
  logic [3:0]        round_q, round_d;
  logic              error_q, error_d;

  logic              sub_load, byte_done, word_done, timeout;
  logic [WORD_W-1:0] sub_word, t, n0, n1, n2, n3;

  sub_word_seq #(
    .SBOX_TIMEOUT(SBOX_TIMEOUT)
  ) u_sub_word_seq (
    .clk            (clk),
    .reset          (reset),
    .load_i         (sub_load),
    .word_i         (words_q[WORD_W-1:0]),
    .req_i          (state_q == StSubReq),
    .wait_i         (state_q == StSubWait),
    .sbox_done_i    (sbox_done),
    .sbox_data_out_i(sbox_data_out),
    .sbox_enable_o  (sbox_enable),
    .sbox_data_in_o (sbox_data_in),
    .byte_done_o    (byte_done),
    .word_done_o    (word_done),
    .timeout_o      (timeout),
    .word_o         (sub_word)
  );

  always_comb begin
    t  = sub_word ^ {rcon_q, 24'h0};
    n0 = words_q[127:96] ^ t;
    n1 = words_q[95:64] ^ n0;
    n2 = words_q[63:32] ^ n1;
    n3 = words_q[31:0] ^ n2;
  end

  always_comb begin
    state_d         = state_q;
    words_d         = words_q;
    rk_d            = rk_q;
    rcon_d          = rcon_q;
    round_d         = round_q;
    error_d         = error_q;
    sub_load        = 1'b0;
    round_key_valid = 1'b0;
    done            = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          words_d = key_in;
          rcon_d  = RCON_INIT;
          round_d = '0;
          error_d = 1'b0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        rk_d    = words_q;
        state_d = StEmit;
      end
      StEmit: begin
        round_key_valid = 1'b1;
        if (round_q == 4'(NUM_ROUNDS)) begin
          done    = 1'b1;
          state_d = StIdle;
        end else begin
          round_d  = round_q + 4'd1;
          sub_load = 1'b1;
          state_d  = StSubReq;
        end
      end
      StSubReq: begin
        state_d = StSubWait;
      end
      StSubWait: begin
        if (word_done) begin
          state_d = StMix;
        end else if (byte_done) begin
          state_d = StSubReq;
        end else if (timeout) begin
          error_d = 1'b1;
          state_d = StIdle;
        end
      end
      StMix: begin
        words_d = {n0, n1, n2, n3};
        rk_d    = {n0, n1, n2, n3};
        rcon_d  = xtime(rcon_q);
        state_d = StEmit;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      words_q <= '0;
      rk_q    <= '0;
      rcon_q  <= RCON_INIT;
      round_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      words_q <= words_d;
      rk_q    <= rk_d;
      rcon_q  <= rcon_d;
      round_q <= round_d;
      error_q <= error_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign round_key = rk_q;
  assign round_idx = round_q;
  assign error     = error_q;

endmodule
